// File: rtl/avg_frame_ctrl.sv
// Frame-level sequencer for the vector generator: clears the back buffer, starts
// avg_core, waits for halt and pipeline drain, then swaps buffers on the next frame tick.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | not running; a frame tick with enable starts a frame
// CLEAR   | writing zeros to every back-buffer word
// GO      | one-cycle vggo start pulse to avg_core
// HOLD    | blanking window where a stale avg_halt is ignored
// RUN     | avg_core drawing; exits on halt or on timeout
// DRAIN   | waiting for line queue empty and rasterizer idle
// WAIT_VB | frame finished, waiting for the next frame tick
// SWAP    | front/back exchanged; restart or go idle
module avg_frame_ctrl #(
    parameter int CLEAR_WORDS = 19200,
    parameter int ADDR_W      = 15,
    parameter int GO_HOLD     = 32,
    parameter int RUN_TIMEOUT = 1000000,
    parameter int TO_W        = 20
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              enable,
    input  logic              frame_tick,
    input  logic              avg_halt,
    input  logic              queue_empty,
    input  logic              raster_busy,
    input  logic              clr_ready,
    input  logic              overrun_clr,
    output logic              vggo,
    output logic              clr_valid,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              front_sel,
    output logic              busy,
    output logic              overrun,
    output logic [7:0]        dropped_cnt,
    output logic [2:0]        state_dbg
);

    localparam int HOLD_W = (GO_HOLD > 1) ? $clog2(GO_HOLD) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLEAR_WORDS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(GO_HOLD - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(RUN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_GO      = 3'd2,
        S_HOLD    = 3'd3,
        S_RUN     = 3'd4,
        S_DRAIN   = 3'd5,
        S_WAIT_VB = 3'd6,
        S_SWAP    = 3'd7
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              en_at_tick;
    logic              clr_last;
    logic              hold_done;
    logic              run_expired;
    logic              timeout_hit;
    logic              drop_tick;

    assign clr_last    = (clr_addr == LAST_ADDR);
    assign hold_done   = (hold_cnt == '0);
    assign run_expired = (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (frame_tick && enable)           state_nxt = S_CLEAR;
            S_CLEAR:   if (clr_ready && clr_last)          state_nxt = S_GO;
            S_GO:                                          state_nxt = S_HOLD;
            S_HOLD:    if (hold_done)                      state_nxt = S_RUN;
            S_RUN:     if (avg_halt || run_expired)        state_nxt = S_DRAIN;
            S_DRAIN:   if (queue_empty && !raster_busy)    state_nxt = S_WAIT_VB;
            S_WAIT_VB: if (frame_tick)                     state_nxt = S_SWAP;
            S_SWAP:    state_nxt = en_at_tick ? S_CLEAR : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        vggo        = 1'b0;
        clr_valid   = 1'b0;
        busy        = 1'b1;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE:    busy        = 1'b0;
            S_CLEAR:   clr_valid   = 1'b1;
            S_GO:      vggo        = 1'b1;
            S_RUN:     timeout_hit = !avg_halt && run_expired;
            S_WAIT_VB: busy        = 1'b0;
            default:   ;
        endcase
        state_dbg = state;
    end

    // Ticks arriving mid-frame are only counted; they never queue a swap.
    assign drop_tick = frame_tick && busy;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            clr_addr    <= '0;
            hold_cnt    <= '0;
            to_cnt      <= '0;
            en_at_tick  <= 1'b0;
            front_sel   <= 1'b0;
            overrun     <= 1'b0;
            dropped_cnt <= 8'd0;
        end else begin
            if (state == S_CLEAR) begin
                if (clr_ready) begin
                    clr_addr <= clr_last ? '0 : clr_addr + ADDR_W'(1);
                end
            end else begin
                clr_addr <= '0;
            end

            if (state == S_GO) begin
                hold_cnt <= HOLD_LOAD;
            end else if (state == S_HOLD && !hold_done) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end

            if (state == S_RUN) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end

            // Enable is captured at the frame tick so a late drop still finishes the swap.
            if (state == S_WAIT_VB && frame_tick) begin
                en_at_tick <= enable;
                front_sel  <= ~front_sel;
            end

            if (timeout_hit) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            if (drop_tick && dropped_cnt != 8'hFF) begin
                dropped_cnt <= dropped_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_avg_frame_ctrl.sv
// Bench for avg_frame_ctrl: table vectors for a nominal frame, directed corner
// sequences, then random stimulus against a frame-phase reference model.
module tb_avg_frame_ctrl;

    localparam int CW = 4;
    localparam int AW = 3;
    localparam int GH = 3;
    localparam int RT = 20;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          enable;
    logic          frame_tick;
    logic          avg_halt;
    logic          queue_empty;
    logic          raster_busy;
    logic          clr_ready;
    logic          overrun_clr;
    logic          vggo;
    logic          clr_valid;
    logic [AW-1:0] clr_addr;
    logic          front_sel;
    logic          busy;
    logic          overrun;
    logic [7:0]    dropped_cnt;
    logic [2:0]    state_dbg;

    avg_frame_ctrl #(
        .CLEAR_WORDS (CW),
        .ADDR_W      (AW),
        .GO_HOLD     (GH),
        .RUN_TIMEOUT (RT),
        .TO_W        (TW)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .enable      (enable),
        .frame_tick  (frame_tick),
        .avg_halt    (avg_halt),
        .queue_empty (queue_empty),
        .raster_busy (raster_busy),
        .clr_ready   (clr_ready),
        .overrun_clr (overrun_clr),
        .vggo        (vggo),
        .clr_valid   (clr_valid),
        .clr_addr    (clr_addr),
        .front_sel   (front_sel),
        .busy        (busy),
        .overrun     (overrun),
        .dropped_cnt (dropped_cnt),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       tick;
        logic       en;
        logic       halt;
        logic [2:0] st;
        logic       vg;
        logic [2:0] addr;
        logic       front;
    } vec_t;

    vec_t tbl [21];

    // Reference model: frame phase plus elapsed-cycle counts.
    int m_ph, m_addr, m_hold, m_run, m_drop;
    bit m_front, m_ovr, m_en;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic wait_state(input string name, input int s, input int limit);
        int n = 0;
        while (int'(state_dbg) != s && n < limit) begin
            next_cyc();
            n++;
        end
        chk(name, 32'(state_dbg), 32'(s));
    endtask

    task automatic model_reset();
        m_ph = 0; m_addr = 0; m_hold = 0; m_run = 0; m_drop = 0;
        m_front = 0; m_ovr = 0; m_en = 0;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        enable = 1'b0; frame_tick = 1'b0; avg_halt = 1'b0;
        queue_empty = 1'b1; raster_busy = 1'b0; clr_ready = 1'b1; overrun_clr = 1'b0;
        model_reset();
        repeat (2) next_cyc();
        rst_b = 1'b1;
    endtask

    function automatic logic [18:0] dut_vec();
        return {state_dbg, vggo, clr_valid, clr_addr, front_sel, busy, overrun, dropped_cnt};
    endfunction

    function automatic logic [18:0] model_vec();
        return {3'(m_ph), 1'(m_ph == 2), 1'(m_ph == 1), 3'(m_addr), 1'(m_front),
                1'(!(m_ph == 0 || m_ph == 6)), 1'(m_ovr), 8'(m_drop)};
    endfunction

    function automatic void model_step();
        int nx = m_ph;
        bit to_hit = 0;
        if (frame_tick && !(m_ph == 0 || m_ph == 6) && m_drop < 255) m_drop++;
        case (m_ph)
            0: if (frame_tick && enable) begin nx = 1; m_addr = 0; end
            1: if (clr_ready) begin
                   if (m_addr == CW - 1) begin m_addr = 0; nx = 2; end
                   else m_addr++;
               end
            2: begin nx = 3; m_hold = 0; end
            3: begin m_hold++; if (m_hold == GH) begin nx = 4; m_run = 0; end end
            4: begin
                   m_run++;
                   if (avg_halt) nx = 5;
                   else if (m_run == RT) begin nx = 5; to_hit = 1; end
               end
            5: if (queue_empty && !raster_busy) nx = 6;
            6: if (frame_tick) begin nx = 7; m_front = !m_front; m_en = enable; end
            7: nx = m_en ? 1 : 0;
            default: nx = 0;
        endcase
        if (to_hit) m_ovr = 1;
        else if (overrun_clr) m_ovr = 0;
        m_ph = nx;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc;
        // tick en halt | state vggo addr front
        tbl[0]  = '{1, 1, 0, 3'd0, 0, 3'd0, 0};
        tbl[1]  = '{0, 1, 0, 3'd1, 0, 3'd0, 0};
        tbl[2]  = '{0, 1, 0, 3'd1, 0, 3'd1, 0};
        tbl[3]  = '{0, 1, 0, 3'd1, 0, 3'd2, 0};
        tbl[4]  = '{0, 1, 0, 3'd1, 0, 3'd3, 0};
        tbl[5]  = '{0, 1, 0, 3'd2, 1, 3'd0, 0};
        tbl[6]  = '{0, 1, 0, 3'd3, 0, 3'd0, 0};
        tbl[7]  = '{0, 1, 0, 3'd3, 0, 3'd0, 0};
        tbl[8]  = '{0, 1, 0, 3'd3, 0, 3'd0, 0};
        tbl[9]  = '{0, 1, 0, 3'd4, 0, 3'd0, 0};
        tbl[10] = '{0, 1, 0, 3'd4, 0, 3'd0, 0};
        tbl[11] = '{0, 1, 0, 3'd4, 0, 3'd0, 0};
        tbl[12] = '{0, 1, 0, 3'd4, 0, 3'd0, 0};
        tbl[13] = '{0, 1, 0, 3'd4, 0, 3'd0, 0};
        tbl[14] = '{0, 1, 1, 3'd4, 0, 3'd0, 0};
        tbl[15] = '{0, 1, 1, 3'd5, 0, 3'd0, 0};
        tbl[16] = '{0, 1, 1, 3'd6, 0, 3'd0, 0};
        tbl[17] = '{1, 1, 1, 3'd6, 0, 3'd0, 0};
        tbl[18] = '{0, 1, 1, 3'd7, 0, 3'd0, 1};
        tbl[19] = '{0, 0, 1, 3'd1, 0, 3'd0, 1};
        tbl[20] = '{0, 0, 1, 3'd1, 0, 3'd1, 1};

        do_reset();
        chk("reset_outputs", 32'(dut_vec()), 32'(19'd0));

        // Nominal frame, cycle by cycle
        for (int i = 0; i < 21; i++) begin
            frame_tick = tbl[i].tick;
            enable     = tbl[i].en;
            avg_halt   = tbl[i].halt;
            chk($sformatf("nominal[%0d]", i), 32'({state_dbg, vggo, clr_addr, front_sel}),
                32'({tbl[i].st, tbl[i].vg, tbl[i].addr, tbl[i].front}));
            next_cyc();
        end
        frame_tick = 1'b0;

        // Stale halt held high, enable already dropped
        wait_state("stale_go", 2, 10);
        next_cyc();
        n = 0;
        while (state_dbg == 3'd3 && n < 10) begin n++; next_cyc(); end
        chk("stale_hold_len", 32'(n), 32'(GH));
        chk("stale_run", 32'(state_dbg), 32'd4);
        next_cyc();
        chk("stale_drain", 32'(state_dbg), 32'd5);
        chk("stale_no_overrun", 32'(overrun), 32'd0);
        next_cyc();
        chk("stale_wait_vb", 32'(state_dbg), 32'd6);
        frame_tick = 1'b1;
        next_cyc();
        frame_tick = 1'b0;
        chk("swap2_state", 32'(state_dbg), 32'd7);
        chk("swap2_front", 32'(front_sel), 32'd0);
        next_cyc();
        chk("disabled_to_idle", 32'(state_dbg), 32'd0);
        chk("no_drops_yet", 32'(dropped_cnt), 32'd0);

        // Backpressure on the clear port
        enable = 1'b1; avg_halt = 1'b0; frame_tick = 1'b1;
        next_cyc();
        frame_tick = 1'b0;
        n = 0; acc = 0;
        while (state_dbg == 3'd1 && n < 20) begin
            clr_ready = (n % 2 == 0);
            chk("bp_addr", 32'(clr_addr), 32'(acc));
            if (clr_ready) acc++;
            n++;
            next_cyc();
        end
        clr_ready = 1'b1;
        chk("bp_accepted", 32'(acc), 32'(CW));
        chk("bp_go", 32'({state_dbg, vggo}), 32'({3'd2, 1'b1}));

        // Run timeout, then overrun clear
        wait_state("to_run", 4, 10);
        n = 0;
        while (state_dbg == 3'd4 && n < 100) begin n++; next_cyc(); end
        chk("to_run_len", 32'(n), 32'(RT));
        chk("to_drain", 32'({state_dbg, overrun}), 32'({3'd5, 1'b1}));
        raster_busy = 1'b1; overrun_clr = 1'b1;
        next_cyc();
        overrun_clr = 1'b0;
        chk("overrun_cleared", 32'(overrun), 32'd0);

        // Drain held by rasterizer with three ticks
        for (int k = 0; k < 50; k++) begin
            frame_tick = (k == 10 || k == 25 || k == 40);
            next_cyc();
        end
        frame_tick = 1'b0;
        chk("drain_hold", 32'({state_dbg, front_sel}), 32'({3'd5, 1'b0}));
        chk("drain_dropped", 32'(dropped_cnt), 32'd3);
        raster_busy = 1'b0;
        next_cyc();
        repeat (3) next_cyc();
        chk("wait_vb_stays", 32'({state_dbg, front_sel}), 32'({3'd6, 1'b0}));
        frame_tick = 1'b1;
        next_cyc();
        frame_tick = 1'b0;
        chk("swap3", 32'({state_dbg, front_sel}), 32'({3'd7, 1'b1}));
        next_cyc();
        chk("restart_clear", 32'({state_dbg, clr_addr}), 32'({3'd1, 3'd0}));

        // Asynchronous reset mid-clear
        next_cyc();
        next_cyc();
        chk("pre_reset_addr", 32'(clr_addr), 32'd2);
        #2 rst_b = 1'b0;
        #1 chk("async_reset", 32'(dut_vec()), 32'(19'd0));
        next_cyc();
        rst_b = 1'b1;
        enable = 1'b0; frame_tick = 1'b1;
        next_cyc();
        frame_tick = 1'b0;
        chk("disabled_tick", 32'({state_dbg, busy, dropped_cnt}), 32'd0);

        // Dropped-tick saturation
        raster_busy = 1'b1; enable = 1'b1; frame_tick = 1'b1;
        next_cyc();
        for (int k = 0; k < 600; k++) begin
            frame_tick = (k % 2 == 0);
            next_cyc();
        end
        frame_tick = 1'b0;
        chk("drop_saturate", 32'(dropped_cnt), 32'd255);
        chk("sat_state", 32'({state_dbg, busy}), 32'({3'd5, 1'b1}));

        // Randomized run against the reference model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            chk("random", 32'(dut_vec()), 32'(model_vec()));
            enable      = ($urandom_range(7) != 0);
            frame_tick  = ($urandom_range(39) == 0);
            avg_halt    = ($urandom_range(9) == 0);
            clr_ready   = ($urandom_range(2) != 0);
            queue_empty = ($urandom_range(3) != 0);
            raster_busy = ($urandom_range(2) == 0);
            overrun_clr = ($urandom_range(49) == 0);
            model_step();
            next_cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/avg_frame_ctrl.md
Name: avg_frame_ctrl

Overview:
- Frame-level sequencer for the vector generator pipeline.
- Per display frame it does three things in order:
  - clears the back framebuffer;
  - pulses vggo to start avg_core;
  - waits for the AVG to halt and for the line queue and rasterizer to drain.
- On the next frame tick it swaps front/back buffers.
- Sits between the display timing generator, avg_core, lineRegQueue/rasterizer and the framebuffer clear port.

Parameters:
- CLEAR_WORDS, 19200, number of framebuffer words written per clear.
- ADDR_W, 15, clr_addr width; must satisfy 2^ADDR_W >= CLEAR_WORDS.
- GO_HOLD, 32, cycles after the vggo pulse during which avg_halt is ignored (covers the core's divided clock).
- RUN_TIMEOUT, 1000000, maximum cycles in RUN before a forced abort.
- TO_W, 20, timeout counter width.

Ports:
- clk, input, 1, system clock.
- rst_b, input, 1, asynchronous active-low reset.
- enable, input, 1, run frames; sampled only in IDLE and at the WAIT_VB tick.
- frame_tick, input, 1, one-cycle pulse per display frame (vblank start).
- avg_halt, input, 1, avg_core halted.
- queue_empty, input, 1, line queue empty.
- raster_busy, input, 1, rasterizer drawing.
- clr_ready, input, 1, framebuffer accepts a clear write.
- overrun_clr, input, 1, clears the overrun flag.
- vggo, output, 1, one-cycle start pulse to avg_core.
- clr_valid, output, 1, clear write request.
- clr_addr, output, ADDR_W, clear write address.
- front_sel, output, 1, buffer being displayed; back buffer = ~front_sel.
- busy, output, 1, high in every state except IDLE and WAIT_VB.
- overrun, output, 1, sticky: a RUN timeout occurred.
- dropped_cnt, output, 8, frame ticks missed while busy.
- state_dbg, output, 3, current state encoding.

Behaviour:
- Single clock domain. Clock is clk; reset is asynchronous and active-low on rst_b.
- Reset values:
  - state = IDLE;
  - vggo = 0, clr_valid = 0, clr_addr = 0;
  - front_sel = 0, overrun = 0, dropped_cnt = 0;
  - all internal counters = 0.
- A reset mid-frame aborts immediately; no clear write or vggo pulse completes after reset.
- State encodings: IDLE=0, CLEAR=1, GO=2, HOLD=3, RUN=4, DRAIN=5, WAIT_VB=6, SWAP=7.
- IDLE:
  - On frame_tick && enable go to CLEAR with clr_addr=0.
  - A tick with enable=0 is ignored and not counted.
- CLEAR:
  - clr_valid=1. Each cycle with clr_valid && clr_ready advances clr_addr by 1.
  - The handshake accepting address CLEAR_WORDS-1 moves to GO; clr_valid is 0 the next cycle and clr_addr returns to 0.
  - With clr_ready held high, CLEAR lasts exactly CLEAR_WORDS cycles.
- GO: vggo=1 for exactly this one cycle; next state HOLD.
- HOLD:
  - A counter runs GO_HOLD cycles, then moves to RUN.
  - avg_halt is ignored throughout, because the stale halt from the previous frame may still read 1.
- RUN:
  - avg_halt=1 moves to DRAIN.
  - A timeout counter counts every cycle spent in RUN. When it reaches RUN_TIMEOUT without halt: set overrun, go to DRAIN.
  - The counter is cleared on entry to RUN.
- DRAIN: wait until queue_empty && !raster_busy (same cycle), then go to WAIT_VB.
- WAIT_VB: on frame_tick go to SWAP.
- SWAP:
  - Lasts one cycle and toggles front_sel.
  - Next state is CLEAR (clr_addr=0) if enable was 1 at the WAIT_VB tick, else IDLE.
- dropped_cnt:
  - Increments by 1 on every frame_tick seen in CLEAR, GO, HOLD, RUN, DRAIN or SWAP.
  - Saturates at 255.
  - The tick is otherwise discarded; it never queues a swap.
- overrun:
  - Set on timeout, cleared by overrun_clr.
  - Set wins if both happen in the same cycle.
- Exactly one vggo pulse per frame. front_sel never changes outside SWAP.
- enable dropping mid-frame does not abort; the frame completes through SWAP, then IDLE.

Test Plan:
(CLEAR_WORDS=4, GO_HOLD=3, RUN_TIMEOUT=20; clr_ready=1, queue_empty=1, raster_busy=0 unless noted.)
- Nominal frame: enable=1, tick at cycle 0; avg_halt drops, then rises 5 cycles into RUN.
  - clr_addr 0,1,2,3 on cycles 1–4; vggo=1 on cycle 5 only.
  - RUN reached at cycle 9; WAIT_VB 2 cycles after halt.
  - Next tick → front_sel 0→1 and CLEAR restarts.
- Backpressure: clr_ready toggles 1,0,1,0,… in CLEAR → clr_addr holds while ready=0; exactly 4 accepted writes, addresses 0–3, each once.
- Stale halt: avg_halt held 1 throughout → HOLD lasts 3 cycles, then RUN exits to DRAIN the next cycle; overrun stays 0.
- Timeout: avg_halt=0 forever → after 20 RUN cycles overrun=1 and state=DRAIN; overrun_clr pulse → overrun=0.
- Drain and dropped ticks: raster_busy=1 for 50 cycles in DRAIN with 3 ticks arriving → dropped_cnt=3, front_sel unchanged. After busy falls → WAIT_VB, swap only on the 4th tick.
- Reset and disable:
  - rst_b low mid-CLEAR (clr_addr=2) → all outputs return to reset values asynchronously.
  - After reset: enable=0, tick → stays IDLE, dropped_cnt=0.
  - 300 ticks while busy → dropped_cnt saturates at 255.
